// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types and default sizing for the issue-stage hazard scoreboard.
// Also holds the latency classes used by the ID and EX datapaths.
package pipe_hazard_scoreboard_pkg;

    localparam int DEF_NREGS   = 32;
    localparam int DEF_ADDR_W  = $clog2(DEF_NREGS);
    localparam int DEF_LAT_MAX = 3;
    localparam int DEF_CW      = $clog2(DEF_LAT_MAX + 1);

    localparam int XZR      = 31;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_CW-1:0]     lat_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage (master) and the hazard scoreboard (slave).
interface pipe_hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CW     = 2
);
    logic              issue_valid;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_rd;
    logic [CW-1:0]     issue_lat;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic              use_a;
    logic              use_b;
    logic              flush;
    logic              stall;
    logic              fwd_a;
    logic              fwd_b;
    logic [ADDR_W:0]   pending;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat,
        output src_a, src_b, use_a, use_b, flush,
        input  stall, fwd_a, fwd_b, pending
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat,
        input  src_a, src_b, use_a, use_b, flush,
        output stall, fwd_a, fwd_b, pending
    );

endinterface

// File: rtl/pipe_hazard_scoreboard_cnt.sv
// Per-register pending-write countdown: load has priority over decrement, stops at zero.
// Next-state is exported so the top can count busy registers without an extra cycle.
module pipe_hazard_scoreboard_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = load_val;
        else if (cnt != '0)
            cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Issue-stage scoreboard: per-register result countdowns drive RAW/WAW stall and bypass select
// for the instruction sitting in ID.
module pipe_hazard_scoreboard
    import pipe_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int LAT_MAX  = DEF_LAT_MAX,
    parameter int FWD_EN   = 1,
    parameter int ZERO_REG = XZR
) (
    input  logic clk,
    input  logic reset,
    pipe_hazard_scoreboard_if.slave sb
);

    localparam int                CW    = $clog2(LAT_MAX + 1);
    localparam logic [ADDR_W-1:0] ZR    = ADDR_W'(ZERO_REG);
    localparam logic [CW-1:0]     LMAX  = CW'(LAT_MAX);
    localparam bit                FWD   = (FWD_EN != 0);

    logic [CW-1:0]   cnt     [NREGS];
    logic [CW-1:0]   cnt_nxt [NREGS];
    logic [CW-1:0]   cnt_a, cnt_b, cnt_rd;
    logic [CW-1:0]   lat_eff;
    logic            raw, waw, accept;
    logic [ADDR_W:0] busy_cnt;

    function automatic logic ready(input logic [ADDR_W-1:0] s, input logic [CW-1:0] c);
        return (s == ZR) || (c == '0) || (FWD && (c == CW'(1)));
    endfunction

    // Sources read the pre-load state, so an instruction never waits on its own destination.
    assign cnt_a   = cnt[sb.src_a];
    assign cnt_b   = cnt[sb.src_b];
    assign cnt_rd  = cnt[sb.issue_rd];
    assign lat_eff = (sb.issue_lat > LMAX) ? LMAX : sb.issue_lat;

    assign raw = (sb.use_a && !ready(sb.src_a, cnt_a)) ||
                 (sb.use_b && !ready(sb.src_b, cnt_b));
    assign waw = sb.issue_we && (sb.issue_rd != ZR) && (cnt_rd > lat_eff);

    assign sb.stall = sb.issue_valid && !sb.flush && (raw || waw);
    assign sb.fwd_a = sb.use_a && sb.issue_valid && FWD && (sb.src_a != ZR) && (cnt_a == CW'(1));
    assign sb.fwd_b = sb.use_b && sb.issue_valid && FWD && (sb.src_b != ZR) && (cnt_b == CW'(1));

    assign accept = sb.issue_valid && !sb.stall && !sb.flush && sb.issue_we && (sb.issue_rd != ZR);

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign cnt[r]     = '0;
            assign cnt_nxt[r] = '0;
        end else begin : g_cnt
            pipe_hazard_scoreboard_cnt #(.CW(CW)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .load     (accept && (sb.issue_rd == ADDR_W'(r))),
                .load_val (lat_eff),
                .cnt      (cnt[r]),
                .cnt_nxt  (cnt_nxt[r])
            );
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int r = 0; r < NREGS; r++)
            if (cnt_nxt[r] != '0)
                busy_cnt = busy_cnt + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sb.pending <= '0;
        else
            sb.pending <= busy_cnt;
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench: DUT a has bypass and LAT_MAX=3, DUT b has no bypass and LAT_MAX=2.
// Observed vector per DUT is {stall, fwd_a, fwd_b, pending[5:0]}.
module tb_pipe_hazard_scoreboard;
    import pipe_hazard_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [8:0] exp_v;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.ADDR_W(5), .CW(2)) ia ();
    pipe_hazard_scoreboard_if #(.ADDR_W(5), .CW(2)) ib ();

    pipe_hazard_scoreboard #(
        .NREGS(32), .ADDR_W(5), .LAT_MAX(3), .FWD_EN(1), .ZERO_REG(XZR)
    ) u_a (
        .clk   (clk),
        .reset (reset),
        .sb    (ia)
    );

    pipe_hazard_scoreboard #(
        .NREGS(32), .ADDR_W(5), .LAT_MAX(2), .FWD_EN(0), .ZERO_REG(XZR)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .sb    (ib)
    );

    function automatic logic [8:0] obs_a();
        return {ia.stall, ia.fwd_a, ia.fwd_b, ia.pending};
    endfunction

    function automatic logic [8:0] obs_b();
        return {ib.stall, ib.fwd_a, ib.fwd_b, ib.pending};
    endfunction

    task automatic drv_a(input logic v, input logic we, input reg_addr_t rd, input lat_t lat,
                         input reg_addr_t sa, input logic ua, input reg_addr_t sbr, input logic ub,
                         input logic fl);
        ia.issue_valid = v;   ia.issue_we = we; ia.issue_rd = rd; ia.issue_lat = lat;
        ia.src_a       = sa;  ia.use_a    = ua; ia.src_b    = sbr; ia.use_b   = ub;
        ia.flush       = fl;
    endtask

    task automatic drv_b(input logic v, input logic we, input reg_addr_t rd, input lat_t lat,
                         input reg_addr_t sa, input logic ua, input reg_addr_t sbr, input logic ub,
                         input logic fl);
        ib.issue_valid = v;   ib.issue_we = we; ib.issue_rd = rd; ib.issue_lat = lat;
        ib.src_a       = sa;  ib.use_a    = ua; ib.src_b    = sbr; ib.use_b   = ub;
        ib.flush       = fl;
    endtask

    task automatic idle_both();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        idle_both();
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv_a(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
                  5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            drv_b(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
                  5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            #1;
            exp_v = 9'd0;
            checks++; if (obs_a() !== exp_v) $display("FAIL reset_hold_a: got %b want %b", obs_a(), exp_v); else passed++;
            checks++; if (obs_b() !== exp_v) $display("FAIL reset_hold_b: got %b want %b", obs_b(), exp_v); else passed++;
        end
        @(negedge clk);
        idle_both();
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL reset_rel_a: got %b want %b", obs_a(), exp_v); else passed++;
        checks++; if (obs_b() !== exp_v) $display("FAIL reset_rel_b: got %b want %b", obs_b(), exp_v); else passed++;
    endtask

    task automatic test_load_use_fwd();
        @(negedge clk); drv_a(1, 1, 1, 2'(LAT_LOAD), 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL ldfwd_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 1, 1, 0, 0, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL ldfwd_stall: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL ldfwd_bypass: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL ldfwd_regfile: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_load_use_nofwd();
        @(negedge clk); drv_b(1, 1, 1, 2'(LAT_LOAD), 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_b() !== exp_v) $display("FAIL ldnf_issue: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); drv_b(1, 0, 0, 0, 1, 1, 0, 0, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_b() !== exp_v) $display("FAIL ldnf_stall1: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); #1;
        checks++; if (obs_b() !== exp_v) $display("FAIL ldnf_stall2: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_b() !== exp_v) $display("FAIL ldnf_go: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_alu_back_to_back();
        // Reads its own destination in the issue cycle: must see the old (idle) counter.
        @(negedge clk); drv_a(1, 1, 2, 2'(LAT_ALU), 2, 1, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL alu_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 0, 0, 2, 1, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b1, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL alu_bypass: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL alu_regfile: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_waw();
        @(negedge clk); drv_a(1, 1, 3, 3, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 1, 3, 1, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_stall3: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_stall2: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_accept: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 3, 1, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_loaded: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both(); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL waw_drain: got %b want %b", obs_a(), exp_v); else passed++;
    endtask

    task automatic test_xzr_flush();
        @(negedge clk); drv_a(1, 1, 5'(XZR), 3, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL xzr_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 1, 5'(XZR), 3, 5'(XZR), 1, 5'(XZR), 1, 0); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL xzr_read: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 1, 4, 3, 0, 0, 0, 0, 1); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL flush_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 1, 5, 3, 0, 0, 0, 0, 0); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL flush_noload: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 5, 1, 4, 1, 1); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL flush_prio: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 5, 1, 4, 1, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL flush_noflush: got %b want %b", obs_a(), exp_v); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_both();
        end
    endtask

    task automatic test_lat_zero();
        @(negedge clk); drv_a(1, 1, 9, 0, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL lat0_issue: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 9, 1, 9, 1, 0); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL lat0_read: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_saturation();
        // LAT_MAX=2 on this instance: a latency of 3 must behave exactly like 2.
        @(negedge clk); drv_b(1, 1, 6, 3, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_b() !== exp_v) $display("FAIL sat_issue: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); drv_b(1, 0, 0, 0, 6, 1, 0, 0, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_b() !== exp_v) $display("FAIL sat_stall1: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); #1;
        checks++; if (obs_b() !== exp_v) $display("FAIL sat_stall2: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_b() !== exp_v) $display("FAIL sat_release: got %b want %b", obs_b(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_reload();
        @(negedge clk); drv_a(1, 1, 7, 3, 0, 0, 0, 0, 0); #1;
        @(negedge clk); drv_a(1, 1, 7, 3, 0, 0, 0, 0, 0); #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL reload_accept: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); drv_a(1, 0, 0, 0, 7, 1, 0, 0, 0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL reload_cnt3: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL reload_cnt2: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL reload_cnt1: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drv_a(1, 1, 8, 3, 0, 0, 0, 0, 0);
        drv_b(1, 1, 8, 2, 0, 0, 0, 0, 0);
        @(negedge clk);
        drv_a(1, 0, 0, 0, 8, 1, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
        checks++; if (obs_a() !== exp_v) $display("FAIL arst_before: got %b want %b", obs_a(), exp_v); else passed++;
        #1 reset = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, 1'b0, 6'd0};
        checks++; if (obs_a() !== exp_v) $display("FAIL arst_during_a: got %b want %b", obs_a(), exp_v); else passed++;
        checks++; if (obs_b() !== exp_v) $display("FAIL arst_during_b: got %b want %b", obs_b(), exp_v); else passed++;
        #1 reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (obs_a() !== exp_v) $display("FAIL arst_after: got %b want %b", obs_a(), exp_v); else passed++;
        @(negedge clk); idle_both();
    endtask

    initial begin
        test_reset();
        test_load_use_fwd();
        test_load_use_nofwd();
        test_alu_back_to_back();
        test_waw();
        test_xzr_flush();
        test_lat_zero();
        test_saturation();
        test_reload();
        test_async_reset();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
